// File: rtl/regfile_write_arbiter_pkg.sv
// Shared types and constants for the register-file write arbiter and its holding slots.
package regfile_write_arbiter_pkg;

    localparam int REG_W  = 3;
    localparam int DATA_W = 16;

    localparam logic REQ_ALU = 1'b0;
    localparam logic REQ_LD  = 1'b1;

    typedef logic [REG_W-1:0]  reg_num_t;
    typedef logic [DATA_W-1:0] data_t;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_SWITCH = 2'd2,
        ST_ACK    = 2'd3
    } arb_state_e;

endpackage

// File: rtl/regfile_write_slot.sv
// One-entry holding slot for a writeback requester, with a saturating wait counter
// that flags the slot as starved once it has been loaded for STARVE_LIMIT cycles.
module regfile_write_slot
    import regfile_write_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic     clk,
    input  logic     rst_n,
    input  logic     load_i,
    input  reg_num_t reg_num_i,
    input  data_t    data_i,
    input  logic     clear_i,
    output logic     valid_o,
    output reg_num_t reg_num_o,
    output data_t    data_o,
    output logic     starved_o
);

    localparam int LIMIT = (STARVE_LIMIT < 1) ? 1 : STARVE_LIMIT;
    localparam int CNT_W = $clog2(LIMIT + 1);
    localparam logic [CNT_W-1:0] WAIT_MAX = CNT_W'(LIMIT - 1);

    logic             valid_q, valid_d;
    reg_num_t         reg_num_q, reg_num_d;
    data_t            data_q, data_d;
    logic [CNT_W-1:0] wait_q, wait_d;

    // Load and clear are mutually exclusive: load needs an empty slot, clear a full one.
    always_comb begin
        valid_d   = valid_q;
        reg_num_d = reg_num_q;
        data_d    = data_q;
        wait_d    = wait_q;
        if (clear_i) begin
            valid_d = 1'b0;
            wait_d  = '0;
        end else if (load_i) begin
            valid_d   = 1'b1;
            reg_num_d = reg_num_i;
            data_d    = data_i;
            wait_d    = '0;
        end else if (valid_q && (wait_q != WAIT_MAX)) begin
            wait_d = wait_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q   <= 1'b0;
            reg_num_q <= '0;
            data_q    <= '0;
            wait_q    <= '0;
        end else begin
            valid_q   <= valid_d;
            reg_num_q <= reg_num_d;
            data_q    <= data_d;
            wait_q    <= wait_d;
        end
    end

    assign valid_o   = valid_q;
    assign reg_num_o = reg_num_q;
    assign data_o    = data_q;
    assign starved_o = valid_q && (wait_q == WAIT_MAX);

endmodule

// File: rtl/regfile_write_arbiter.sv
// Arbitrates ALU and load writebacks onto one register-file write port and sequences bank switches.
// Define REGFILE_ARB_RR_EN for round-robin normal priority; otherwise load is always preferred.
module regfile_write_arbiter
    import regfile_write_arbiter_pkg::*;
#(
    parameter bit BANK_RESET   = 1'b0,
    parameter int STARVE_LIMIT = 4
) (
    input  logic     clk,
    input  logic     rst_n,
    input  logic     alu_valid,
    output logic     alu_ready,
    input  reg_num_t alu_reg_num,
    input  data_t    alu_data,
    input  logic     ld_valid,
    output logic     ld_ready,
    input  reg_num_t ld_reg_num,
    input  data_t    ld_data,
    input  logic     bank_switch_req,
    input  logic     bank_switch_target,
    output logic     bank_switch_ack,
    output reg_num_t write_register_num,
    output data_t    write_register_in,
    output logic     write_en,
    output logic     active_bank,
    output logic     busy
);

    arb_state_e state_q, state_d;
    logic       target_q, target_d;
    logic       bank_q, bank_d;
    logic       we_q, we_d;
    reg_num_t   wnum_q, wnum_d;
    data_t      wdata_q, wdata_d;

    logic     alu_v, ld_v, alu_starved, ld_starved;
    reg_num_t alu_num, ld_num;
    data_t    alu_dat, ld_dat;
    logic     grant_en, prefer_ld, pick_ld, grant_alu, grant_ld;

    regfile_write_slot #(.STARVE_LIMIT(STARVE_LIMIT)) u_alu_slot (
        .clk       (clk),
        .rst_n     (rst_n),
        .load_i    (alu_valid && alu_ready),
        .reg_num_i (alu_reg_num),
        .data_i    (alu_data),
        .clear_i   (grant_alu),
        .valid_o   (alu_v),
        .reg_num_o (alu_num),
        .data_o    (alu_dat),
        .starved_o (alu_starved)
    );

    regfile_write_slot #(.STARVE_LIMIT(STARVE_LIMIT)) u_ld_slot (
        .clk       (clk),
        .rst_n     (rst_n),
        .load_i    (ld_valid && ld_ready),
        .reg_num_i (ld_reg_num),
        .data_i    (ld_data),
        .clear_i   (grant_ld),
        .valid_o   (ld_v),
        .reg_num_o (ld_num),
        .data_o    (ld_dat),
        .starved_o (ld_starved)
    );

`ifdef REGFILE_ARB_RR_EN
    // Pointer names the requester granted last; it yields the next tie.
    logic rr_q, rr_d;

    always_comb begin
        rr_d = rr_q;
        if (grant_ld) begin
            rr_d = REQ_LD;
        end else if (grant_alu) begin
            rr_d = REQ_ALU;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_q <= REQ_ALU;
        end else begin
            rr_q <= rr_d;
        end
    end

    assign prefer_ld = (rr_q == REQ_ALU);
`else
    assign prefer_ld = 1'b1;
`endif

    // Starvation overrides normal priority; if both starve, the normally disfavoured side wins.
    always_comb begin
        if (alu_starved && ld_starved) begin
            pick_ld = !prefer_ld;
        end else if (alu_starved) begin
            pick_ld = 1'b0;
        end else if (ld_starved) begin
            pick_ld = 1'b1;
        end else begin
            pick_ld = prefer_ld;
        end
        grant_en  = (state_q == ST_RUN) || (state_q == ST_DRAIN);
        grant_ld  = grant_en && ld_v && (!alu_v || pick_ld);
        grant_alu = grant_en && alu_v && (!ld_v || !pick_ld);
    end

    always_comb begin
        state_d  = state_q;
        target_d = target_q;
        bank_d   = bank_q;
        we_d     = grant_alu || grant_ld;
        wnum_d   = wnum_q;
        wdata_d  = wdata_q;
        if (grant_ld) begin
            wnum_d  = ld_num;
            wdata_d = ld_dat;
        end else if (grant_alu) begin
            wnum_d  = alu_num;
            wdata_d = alu_dat;
        end
        case (state_q)
            ST_RUN: begin
                if (bank_switch_req) begin
                    state_d  = ST_DRAIN;
                    target_d = bank_switch_target;
                end
            end
            // With both slots empty no grant can be issued this cycle.
            ST_DRAIN: begin
                if (!alu_v && !ld_v) begin
                    state_d = ST_SWITCH;
                end
            end
            ST_SWITCH: begin
                bank_d  = target_q;
                state_d = ST_ACK;
            end
            ST_ACK: begin
                state_d = ST_RUN;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_RUN;
            target_q <= 1'b0;
            bank_q   <= BANK_RESET;
            we_q     <= 1'b0;
            wnum_q   <= '0;
            wdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            target_q <= target_d;
            bank_q   <= bank_d;
            we_q     <= we_d;
            wnum_q   <= wnum_d;
            wdata_q  <= wdata_d;
        end
    end

    assign alu_ready          = !alu_v && (state_q == ST_RUN);
    assign ld_ready           = !ld_v && (state_q == ST_RUN);
    assign bank_switch_ack    = (state_q == ST_ACK);
    assign write_en           = we_q;
    assign write_register_num = wnum_q;
    assign write_register_in  = wdata_q;
    assign active_bank        = bank_q;
    assign busy               = alu_v || ld_v || (state_q != ST_RUN);

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter: writes are scoreboarded as {bank, reg, data}.
module tb_regfile_write_arbiter;
    import regfile_write_arbiter_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic     rst_n;
    logic     alu_valid, alu_ready, ld_valid, ld_ready;
    reg_num_t alu_reg_num, ld_reg_num, write_register_num;
    data_t    alu_data, ld_data, write_register_in;
    logic     bank_switch_req, bank_switch_target, bank_switch_ack;
    logic     write_en, active_bank, busy;

    logic     s_alu_valid, s_alu_ready, s_ld_valid, s_ld_ready;
    reg_num_t s_alu_reg_num, s_ld_reg_num, s_write_register_num;
    data_t    s_alu_data, s_ld_data, s_write_register_in;
    logic     s_bank_switch_ack, s_write_en, s_active_bank, s_busy;

    regfile_write_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_reg_num(alu_reg_num), .alu_data(alu_data),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_reg_num(ld_reg_num), .ld_data(ld_data),
        .bank_switch_req(bank_switch_req), .bank_switch_target(bank_switch_target),
        .bank_switch_ack(bank_switch_ack), .write_register_num(write_register_num),
        .write_register_in(write_register_in), .write_en(write_en),
        .active_bank(active_bank), .busy(busy)
    );

    regfile_write_arbiter #(.BANK_RESET(1'b1), .STARVE_LIMIT(1)) dut_s (
        .clk(clk), .rst_n(rst_n),
        .alu_valid(s_alu_valid), .alu_ready(s_alu_ready), .alu_reg_num(s_alu_reg_num), .alu_data(s_alu_data),
        .ld_valid(s_ld_valid), .ld_ready(s_ld_ready), .ld_reg_num(s_ld_reg_num), .ld_data(s_ld_data),
        .bank_switch_req(1'b0), .bank_switch_target(1'b0),
        .bank_switch_ack(s_bank_switch_ack), .write_register_num(s_write_register_num),
        .write_register_in(s_write_register_in), .write_en(s_write_en),
        .active_bank(s_active_bank), .busy(s_busy)
    );

    int checks = 0;
    int errors = 0;
    logic [19:0] exp_q[$];
    logic [19:0] mon_exp, mon_act;
    logic take;
    int sent, ack_cnt, ack_at, we_cnt;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every write seen on the port must match the oldest expected entry.
    always @(negedge clk) begin
        if (rst_n && write_en) begin
            mon_act = {active_bank, write_register_num, write_register_in};
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write actual=%0h required=none", mon_act);
            end else begin
                mon_exp = exp_q.pop_front();
                if (mon_act !== mon_exp) begin
                    errors++;
                    $display("FAIL write_port actual=%0h required=%0h", mon_act, mon_exp);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        alu_valid = 0; alu_reg_num = '0; alu_data = '0;
        ld_valid = 0; ld_reg_num = '0; ld_data = '0;
        bank_switch_req = 0; bank_switch_target = 0;
        s_alu_valid = 0; s_alu_reg_num = '0; s_alu_data = '0;
        s_ld_valid = 0; s_ld_reg_num = '0; s_ld_data = '0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        check("rst_we", write_en, 0);
        check("rst_num_data", {write_register_num, write_register_in}, 0);
        check("rst_ack", bank_switch_ack, 0);
        check("rst_bank", active_bank, 0);
        check("rst_busy", busy, 0);
        check("rst_ready", {alu_ready, ld_ready}, 2'b11);
        check("s_rst_bank", s_active_bank, 1);
        check("s_rst_misc", {s_write_en, s_bank_switch_ack, s_busy, s_alu_ready, s_ld_ready}, 5'b00011);

        // Single ALU write, latency and no-bypass
        alu_valid = 1; alu_reg_num = 3'd3; alu_data = 16'h1234;
        exp_q.push_back({1'b0, 3'd3, 16'h1234});
        tick();
        alu_valid = 0;
        check("alu_slot_full_ready", alu_ready, 0);
        check("we_before_grant", write_en, 0);
        check("busy_loaded", busy, 1);
        tick();
        check("we_latency1", {write_en, write_register_num, write_register_in}, {1'b1, 3'd3, 16'h1234});
        check("alu_ready_after_grant", alu_ready, 1);
        tick();
        check("we_one_cycle", write_en, 0);
        check("busy_idle", busy, 0);

        // Register 0 forwarded unchanged
        alu_valid = 1; alu_reg_num = 3'd0; alu_data = 16'hBEEF;
        exp_q.push_back({1'b0, 3'd0, 16'hBEEF});
        tick();
        alu_valid = 0;
        repeat (2) tick();

        // Simultaneous requests: load first, then ALU
        alu_valid = 1; alu_reg_num = 3'd1; alu_data = 16'hAAAA;
        ld_valid = 1; ld_reg_num = 3'd2; ld_data = 16'h5555;
        exp_q.push_back({1'b0, 3'd2, 16'h5555});
        exp_q.push_back({1'b0, 3'd1, 16'hAAAA});
        tick();
        alu_valid = 0; ld_valid = 0;
        tick();
        check("tie_first_ld", write_register_num, 3'd2);
        tick();
        check("tie_second_alu", {write_en, write_register_num}, {1'b1, 3'd1});
        tick();

        // Lone load write
        ld_valid = 1; ld_reg_num = 3'd7; ld_data = 16'hFFFF;
        exp_q.push_back({1'b0, 3'd7, 16'hFFFF});
        tick();
        ld_valid = 0;
        tick();
        check("ld_alone_we", write_en, 1);
        tick();

        // Back-to-back loads while the ALU slot waits
        alu_valid = 1; alu_reg_num = 3'd4; alu_data = 16'h4444;
        ld_valid = 1; ld_reg_num = 3'd5; ld_data = 16'h5000;
        exp_q.push_back({1'b0, 3'd5, 16'h5000});
        exp_q.push_back({1'b0, 3'd4, 16'h4444});
        exp_q.push_back({1'b0, 3'd5, 16'h5001});
        exp_q.push_back({1'b0, 3'd5, 16'h5002});
        sent = 0;
        for (int c = 0; c < 8; c++) begin
            take = ld_valid && ld_ready;
            tick();
            if (c == 0) alu_valid = 0;
            if (take) begin
                sent++;
                if (sent == 3) ld_valid = 0;
                else ld_data = 16'h5000 + 16'(sent);
            end
            if (c == 2) check("alu_grant_bound", {write_en, write_register_num}, {1'b1, 3'd4});
        end
        check("stream_sent", sent, 3);

        // Bank switch with both slots loaded
        alu_valid = 1; alu_reg_num = 3'd1; alu_data = 16'h0101;
        ld_valid = 1; ld_reg_num = 3'd2; ld_data = 16'h0202;
        bank_switch_req = 1; bank_switch_target = 1;
        exp_q.push_back({1'b0, 3'd2, 16'h0202});
        exp_q.push_back({1'b0, 3'd1, 16'h0101});
        tick();
        alu_valid = 0; ld_valid = 0; bank_switch_req = 0;
        check("drain_ready_low", {alu_ready, ld_ready}, 2'b00);
        check("drain_busy", busy, 1);
        ack_cnt = 0; ack_at = -1;
        for (int c = 1; c <= 8; c++) begin
            tick();
            if (bank_switch_ack) begin
                ack_cnt++;
                ack_at = c;
                check("bank_at_ack", active_bank, 1);
            end
        end
        check("switch_ack_count", ack_cnt, 1);
        check("switch_ack_cycle", ack_at, 4);
        check("switch_end_state", {active_bank, alu_ready, ld_ready, busy}, 4'b1110);

        // Switch to the bank already active
        bank_switch_req = 1; bank_switch_target = 1;
        tick();
        bank_switch_req = 0;
        check("same_bank_busy", busy, 1);
        ack_cnt = 0; ack_at = -1;
        for (int c = 1; c <= 6; c++) begin
            tick();
            if (bank_switch_ack) begin
                ack_cnt++;
                ack_at = c;
            end
        end
        check("same_bank_ack", {ack_cnt[3:0], ack_at[3:0]}, {4'd1, 4'd2});
        check("same_bank_bank", active_bank, 1);

        // Reset during drain discards everything
        alu_valid = 1; alu_reg_num = 3'd6; alu_data = 16'h6666;
        ld_valid = 1; ld_reg_num = 3'd7; ld_data = 16'h7777;
        bank_switch_req = 1; bank_switch_target = 1;
        tick();
        alu_valid = 0; ld_valid = 0; bank_switch_req = 0;
        #2 rst_n = 1'b0;
        #1;
        check("rstmid_outputs", {write_en, bank_switch_ack, active_bank, busy}, 4'b0000);
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        ack_cnt = 0; we_cnt = 0;
        for (int c = 0; c < 6; c++) begin
            tick();
            if (bank_switch_ack) ack_cnt++;
            if (write_en) we_cnt++;
        end
        check("rstmid_no_ack_we", {ack_cnt[3:0], we_cnt[3:0]}, 8'h00);
        check("rstmid_state", {active_bank, busy, alu_ready, ld_ready}, 4'b0011);

        // Starvation limit of one: both starve at once, ALU overrides fixed priority
        s_alu_valid = 1; s_alu_reg_num = 3'd1; s_alu_data = 16'h1111;
        s_ld_valid = 1; s_ld_reg_num = 3'd2; s_ld_data = 16'h2222;
        tick();
        s_alu_valid = 0; s_ld_valid = 0;
        tick();
        check("starve_first_alu", {s_write_en, s_write_register_num, s_write_register_in}, {1'b1, 3'd1, 16'h1111});
        tick();
        check("starve_second_ld", {s_write_en, s_write_register_num, s_write_register_in}, {1'b1, 3'd2, 16'h2222});
        tick();
        check("starve_idle", {s_write_en, s_busy}, 2'b00);

        repeat (2) tick();
        check("scoreboard_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
